// File: rtl/digest_tx_serializer.sv
// digest_tx_serializer
// Captures a DIGEST_W-bit digest on a one-cycle valid pulse and streams it out
// over a valid/ready byte interface. The stream is either raw bytes or
// lowercase hex ASCII, in MSB-first or LSB-first byte order, with an optional
// CR/LF terminator. The block returns to IDLE after every digest.
module digest_tx_serializer #(
  parameter int DIGEST_W    = 256,
  parameter int APPEND_CRLF = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIGEST_W-1:0] i_digest,
  input  logic                i_digest_valid,
  input  logic                i_hex_mode,
  input  logic                i_msb_first,
  output logic [7:0]          o_byte,
  output logic                o_byte_valid,
  input  logic                i_byte_ready,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_overrun
);

  localparam int N     = DIGEST_W / 8;
  localparam int CNT_W = $clog2(2 * N + 3);

  typedef enum logic [1:0] {IDLE, EMIT, TERM, DONE} state_t;

  state_t              state_q,   state_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [DIGEST_W-1:0] digest_q,  digest_d;
  logic                hex_q,     hex_d;
  logic                msb_q,     msb_d;
  logic [7:0]          byte_q,    byte_d;
  logic                valid_q,   valid_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;
  logic                overrun_q, overrun_d;

  logic                xfer;
  logic [CNT_W-1:0]    last_k;

  // Item k of the digest portion of the stream. In hex mode two consecutive
  // items share one byte: even k is the high nibble, odd k the low nibble.
  function automatic logic [7:0] item_byte(
    input logic [CNT_W-1:0]    k,
    input logic [DIGEST_W-1:0] digest,
    input logic                hex,
    input logic                msb
  );
    int         j;
    int         pos;
    logic [7:0] sel;
    logic [3:0] nib;
    j = hex ? int'(k >> 1) : int'(k);
    // Emission slot j maps to byte j (msb-first) or N-1-j (lsb-first) counted
    // from the MSB; pos is the same byte counted from the LSB.
    pos = msb ? (N - 1 - j) : j;
    sel = 8'(digest >> (pos * 8));
    nib = k[0] ? sel[3:0] : sel[7:4];
    if (!hex) begin
      item_byte = sel;
    end else if (nib < 4'd10) begin
      item_byte = {4'h3, nib};
    end else begin
      item_byte = 8'h57 + {4'h0, nib};
    end
  endfunction

  assign xfer   = valid_q && i_byte_ready;
  // Index of the final digest item for the captured mode.
  assign last_k = hex_q ? CNT_W'(2 * N - 1) : CNT_W'(N - 1);

  // Next-state and next-output computation; every output is registered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    digest_d  = digest_q;
    hex_d     = hex_q;
    msb_d     = msb_q;
    byte_d    = byte_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    overrun_d = i_digest_valid && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (i_digest_valid) begin
          digest_d = i_digest;
          hex_d    = i_hex_mode;
          msb_d    = i_msb_first;
          cnt_d    = '0;
          // Item 0 is built straight from the inputs so it is presented on
          // the capture edge itself.
          byte_d   = item_byte('0, i_digest, i_hex_mode, i_msb_first);
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        if (xfer) begin
          if (cnt_q == last_k) begin
            if (APPEND_CRLF != 0) begin
              byte_d  = 8'h0D;
              cnt_d   = cnt_q + 1'b1;
              state_d = TERM;
            end else begin
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = DONE;
            end
          end else begin
            cnt_d  = cnt_q + 1'b1;
            byte_d = item_byte(cnt_q + 1'b1, digest_q, hex_q, msb_q);
          end
        end
      end
      TERM: begin
        if (xfer) begin
          if (cnt_q == last_k + 1'b1) begin
            byte_d = 8'h0A;
            cnt_d  = cnt_q + 1'b1;
          end else begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any stream immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      digest_q  <= '0;
      hex_q     <= 1'b0;
      msb_q     <= 1'b0;
      byte_q    <= 8'h00;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      digest_q  <= digest_d;
      hex_q     <= hex_d;
      msb_q     <= msb_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_byte       = byte_q;
  assign o_byte_valid = valid_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_digest_tx_serializer.sv
// Testbench for digest_tx_serializer. Two instances run side by side on the
// same stimulus: index 0 without the CR/LF terminator, index 1 with it.
// Expected streams are queued when a digest is issued; a negedge monitor
// pops and compares on every transfer.
`timescale 1ns/1ps
module tb_digest_tx_serializer;

  localparam int DW = 256;
  localparam int N  = DW / 8;
  localparam int QD = 4096;
  localparam int LQ = 256;
  localparam logic [DW-1:0] ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] i_digest;
  logic          i_digest_valid;
  logic          i_hex_mode;
  logic          i_msb_first;
  logic          i_byte_ready;
  logic [7:0]    o_byte [2];
  logic [1:0]    o_byte_valid;
  logic [1:0]    o_busy;
  logic [1:0]    o_done;
  logic [1:0]    o_overrun;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    digest_tx_serializer #(
      .DIGEST_W    (DW),
      .APPEND_CRLF (gi)
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .i_digest       (i_digest),
      .i_digest_valid (i_digest_valid),
      .i_hex_mode     (i_hex_mode),
      .i_msb_first    (i_msb_first),
      .o_byte         (o_byte[gi]),
      .o_byte_valid   (o_byte_valid[gi]),
      .i_byte_ready   (i_byte_ready),
      .o_busy         (o_busy[gi]),
      .o_done         (o_done[gi]),
      .o_overrun      (o_overrun[gi])
    );
  end

  always #5 clk = ~clk;

  // Scoreboard: per-instance ring of expected bytes plus ring of stream lengths.
  logic [7:0] exp_mem [2][QD];
  int         len_mem [2][LQ];
  int         wr_ptr [2];
  int         rd_ptr [2];
  int         lwr [2];
  int         lrd [2];
  int         items_left [2];
  bit         expect_done [2];
  bit         prev_stall [2];
  logic [7:0] prev_byte [2];

  int  checks = 0;
  int  errors = 0;
  bit  rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    string digits;
    digits = "0123456789abcdef";
    return digits[int'(n)];
  endfunction

  // Reference model: list the digest bytes in MSB-first order, reorder as
  // requested, expand to ASCII if asked, and append CR/LF for instance 1.
  task automatic push_stream(input logic [DW-1:0] d, input logic hex, input logic msb);
    logic [7:0] msb_order [N];
    logic [7:0] items [$];
    logic [7:0] b;
    for (int j = 0; j < N; j++) msb_order[j] = 8'(d >> (DW - 8 - 8 * j));
    for (int j = 0; j < N; j++) begin
      b = msb ? msb_order[j] : msb_order[N - 1 - j];
      if (hex) begin
        items.push_back(hexc(b[7:4]));
        items.push_back(hexc(b[3:0]));
      end else begin
        items.push_back(b);
      end
    end
    for (int dd = 0; dd < 2; dd++) begin
      foreach (items[i]) begin
        exp_mem[dd][wr_ptr[dd] % QD] = items[i];
        wr_ptr[dd]++;
      end
      if (dd == 1) begin
        exp_mem[dd][wr_ptr[dd] % QD] = 8'h0D;
        wr_ptr[dd]++;
        exp_mem[dd][wr_ptr[dd] % QD] = 8'h0A;
        wr_ptr[dd]++;
      end
      len_mem[dd][lwr[dd] % LQ] = items.size() + ((dd == 1) ? 2 : 0);
      lwr[dd]++;
    end
  endtask

  // Monitor: compares every transfer, checks hold-while-stalled and the
  // o_done pulse right after each stream's last transfer.
  initial begin
    for (int d = 0; d < 2; d++) begin
      wr_ptr[d] = 0; rd_ptr[d] = 0; lwr[d] = 0; lrd[d] = 0;
      items_left[d] = 0; expect_done[d] = 0; prev_stall[d] = 0; prev_byte[d] = 8'h00;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          rd_ptr[d] = wr_ptr[d];
          lrd[d] = lwr[d];
          items_left[d] = 0;
          expect_done[d] = 0;
          prev_stall[d] = 0;
        end else begin
          if (expect_done[d]) begin
            chk($sformatf("done_pulse_dut%0d", d), {61'd0, o_done[d], o_byte_valid[d], o_busy[d]}, 64'b100);
            expect_done[d] = 0;
          end else if (o_done[d]) begin
            errors++;
            $display("FAIL spurious_done_dut%0d actual=1 required=0", d);
          end
          if (prev_stall[d]) begin
            chk($sformatf("hold_valid_dut%0d", d), 64'(o_byte_valid[d]), 64'd1);
            chk($sformatf("hold_byte_dut%0d", d), 64'(o_byte[d]), 64'(prev_byte[d]));
          end
          if (o_byte_valid[d] && i_byte_ready) begin
            if (items_left[d] == 0) begin
              if (lrd[d] == lwr[d]) begin
                errors++;
                $display("FAIL unexpected_xfer_dut%0d actual=0x%0h required=none", d, o_byte[d]);
              end else begin
                items_left[d] = len_mem[d][lrd[d] % LQ];
                lrd[d]++;
              end
            end
            if (items_left[d] > 0) begin
              chk($sformatf("byte_dut%0d_item%0d", d, rd_ptr[d]), 64'(o_byte[d]),
                  64'(exp_mem[d][rd_ptr[d] % QD]));
              rd_ptr[d]++;
              items_left[d]--;
              if (items_left[d] == 0) expect_done[d] = 1;
            end
          end
          prev_stall[d] = o_byte_valid[d] && !i_byte_ready;
          prev_byte[d]  = o_byte[d];
        end
      end
    end
  end

  // Sink ready: constant high, or pseudo-random when backpressure is enabled.
  initial begin
    i_byte_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i_byte_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(o_busy == 2'b00 && o_done == 2'b00) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) begin
      errors++;
      $display("FAIL wait_idle_timeout actual=busy%b required=busy00", o_busy);
    end
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    while (!o_done[d] && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) begin
      errors++;
      $display("FAIL wait_done_timeout_dut%0d actual=0 required=1", d);
    end
  endtask

  // Pulses i_digest_valid for one cycle (called just after a rising edge).
  task automatic issue(input logic [DW-1:0] d, input logic hex, input logic msb, input bit accept);
    $display("issue digest=%h hex=%0d msb=%0d accept=%0d", d, hex, msb, accept);
    i_digest = d;
    i_hex_mode = hex;
    i_msb_first = msb;
    i_digest_valid = 1'b1;
    if (accept) push_stream(d, hex, msb);
    @(posedge clk);
    #1;
    i_digest_valid = 1'b0;
    // Mode and digest inputs must be ignored outside the capture cycle.
    i_hex_mode = 1'($urandom_range(0, 1));
    i_msb_first = 1'($urandom_range(0, 1));
    for (int w = 0; w < DW / 32; w++) i_digest[w * 32 +: 32] = $urandom();
    if (accept) begin
      chk("busy_after_capture", 64'(o_busy), 64'b11);
      chk("valid_after_capture", 64'(o_byte_valid), 64'b11);
      chk("no_overrun_on_capture", 64'(o_overrun), 64'b00);
    end
  endtask

  function automatic logic [DW-1:0] rand_digest();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w * 32 +: 32] = $urandom();
    return d;
  endfunction

  initial begin
    int n;
    int n0;
    rst = 1'b1;
    i_digest = '0;
    i_digest_valid = 1'b0;
    i_hex_mode = 1'b0;
    i_msb_first = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_byte_dut%0d", d), 64'(o_byte[d]), 64'h00);
    end
    chk("rst_valid", 64'(o_byte_valid), 64'b00);
    chk("rst_busy", 64'(o_busy), 64'b00);
    chk("rst_done", 64'(o_done), 64'b00);
    chk("rst_overrun", 64'(o_overrun), 64'b00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Raw msb-first "abc" digest, ready held high: done at C+N (C+N+2 with CR/LF).
    rand_ready = 1'b0;
    issue(ABC, 1'b0, 1'b1, 1'b1);
    n = 0;
    n0 = -1;
    while (!o_done[1] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (o_done[0] && n0 < 0) n0 = n;
    end
    chk("raw_done_latency_dut0", 64'(n0), 64'(N));
    chk("raw_done_latency_dut1", 64'(n), 64'(N + 2));
    wait_idle();

    // Raw lsb-first, then hex msb-first with and without backpressure.
    issue(ABC, 1'b0, 1'b0, 1'b1);
    wait_idle();
    issue(ABC, 1'b1, 1'b1, 1'b1);
    wait_idle();
    rand_ready = 1'b1;
    issue(ABC, 1'b1, 1'b1, 1'b1);
    wait_idle();

    // Overrun mid-stream: second digest dropped, first completes.
    issue(ABC, 1'b1, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    i_digest = ~ABC;
    i_digest_valid = 1'b1;
    @(posedge clk);
    #1;
    i_digest_valid = 1'b0;
    chk("overrun_pulse", 64'(o_overrun), 64'b11);
    @(posedge clk);
    #1;
    chk("overrun_single_cycle", 64'(o_overrun), 64'b00);
    // Third digest issued so that it is sampled two edges after the last transfer.
    wait_done(1);
    @(posedge clk);
    #1;
    issue(rand_digest(), 1'b0, 1'b1, 1'b1);
    wait_idle();

    // A digest arriving while in DONE is dropped with an overrun pulse.
    rand_ready = 1'b0;
    issue(rand_digest(), 1'b0, 1'b0, 1'b1);
    wait_done(0);
    i_digest = rand_digest();
    i_digest_valid = 1'b1;
    @(posedge clk);
    #1;
    i_digest_valid = 1'b0;
    chk("overrun_in_done", 64'(o_overrun), 64'b11);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("dropped_digest_not_started", 64'(o_busy), 64'b00);

    // Randomized streams with random modes and backpressure.
    rand_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      issue(rand_digest(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      wait_idle();
    end

    // Reset after 10 transfers aborts immediately; a fresh digest then streams.
    rand_ready = 1'b0;
    issue(ABC, 1'b0, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_valid", 64'(o_byte_valid), 64'b00);
    chk("abort_busy", 64'(o_busy), 64'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(o_done), 64'b00);
    rand_ready = 1'b1;
    issue(ABC, 1'b1, 1'b0, 1'b1);
    wait_idle();

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("drained_bytes_dut%0d", d), 64'(wr_ptr[d] - rd_ptr[d]), 64'd0);
      chk($sformatf("drained_streams_dut%0d", d), 64'(lwr[d] - lrd[d]), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/digest_tx_serializer.md
# digest_tx_serializer

Parametrised digest-to-byte-stream serializer between the SHA-256 core and the UART transmitter. It captures a digest of DIGEST_W bits on a one-cycle valid pulse and emits it as a byte stream over a valid/ready handshake. Byte order and raw or lowercase-hex-ASCII encoding are selectable per digest, and a CR/LF terminator can be appended. Unlike the previous single-shot handler, it returns to IDLE after every digest and accepts the next one without a reset.

## Interface
Parameters:
- DIGEST_W, 256, digest width in bits; multiple of 8, range 8..1024
- APPEND_CRLF, 1, when 1 append 0x0D then 0x0A after the digest bytes/characters

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- i_digest  input  DIGEST_W  digest value; bits [DIGEST_W-1 -: 8] are the most significant byte
- i_digest_valid  input  1  one-cycle pulse; i_digest is valid in that cycle
- i_hex_mode  input  1  0 = raw bytes, 1 = two lowercase hex ASCII characters per byte
- i_msb_first  input  1  1 = most significant byte first, 0 = least significant byte first
- o_byte  output  8  outgoing byte/character
- o_byte_valid  output  1  o_byte is valid
- i_byte_ready  input  1  sink accepts o_byte when o_byte_valid && i_byte_ready
- o_busy  output  1  high from the capture cycle until o_done
- o_done  output  1  one-cycle pulse after the last transfer
- o_overrun  output  1  one-cycle pulse when i_digest_valid arrives while busy

## Operation
- N = DIGEST_W/8. Total items T = N (raw) or 2N (hex), plus 2 if APPEND_CRLF.
- States: IDLE, EMIT, TERM, DONE.
- IDLE: on i_digest_valid, register i_digest, i_hex_mode and i_msb_first, clear the item counter, then go to EMIT. Mode inputs are ignored at all other times.
- EMIT: item k selects byte index b = k (msb-first) or N-1-k (lsb-first) counted from the MSB.
  - Raw mode: o_byte = byte b.
  - Hex mode: two items per byte, high nibble first. Nibble 0-9 maps to 0x30-0x39; nibble a-f maps to 0x61-0x66.
  - On each transfer, advance k. After the final digest item, go to TERM if APPEND_CRLF, otherwise go to DONE.
- TERM: emit 0x0D then 0x0A, one per transfer, then go to DONE.
- DONE: pulse o_done for one cycle, drop o_busy, then go to IDLE.
- i_digest_valid outside IDLE (including DONE): the input is dropped, o_overrun pulses, and the stream in progress is unaffected.
- Handshake rules:
  - Once o_byte_valid is raised, o_byte is held stable and o_byte_valid stays high until the transfer occurs.
  - o_byte_valid never depends combinationally on i_byte_ready.

## Timing
- Reset values: o_byte=0x00, o_byte_valid=0, o_busy=0, o_done=0, o_overrun=0, state=IDLE, counter=0, digest register=0.
- Reset mid-stream aborts immediately: o_byte_valid and o_busy fall asynchronously, and no o_done is produced.
- Capture at edge C. From edge C onward, o_busy=1 and o_byte_valid=1 with item 0.
- Items are registered. With i_byte_ready held high, there is one transfer per cycle with no bubbles, including across the EMIT->TERM boundary.
- Last transfer at edge L. o_done=1 and o_byte_valid=0 in the cycle after L. o_busy falls at that same point. The earliest new capture is at edge L+2.
- Raw, no CRLF, ready=1: digest in at edge C, o_done high at edge C+N.
- o_overrun is registered and is high for the single cycle following the offending i_digest_valid.
- The counter is $clog2(2N+3) bits wide, with no wrap within a stream.

## Test plan
- Raw, msb-first, APPEND_CRLF=0: digest of "abc" (0xba7816bf...f20015ad) with ready=1 -> 32 transfers on consecutive cycles. First 0xBA, second 0x78, last 0xAD. o_done one cycle after the last transfer.
- Raw, lsb-first, same digest -> first 0xAD, second 0x15, last 0xBA.
- Hex, msb-first, APPEND_CRLF=1 -> 66 transfers: 0x62 'b', 0x61 'a', 0x37 '7', 0x38 '8' ... 0x61 'a', 0x64 'd', 0x0D, 0x0A.
- Backpressure: ready toggled pseudo-randomly in hex mode -> o_byte stable while valid && !ready. Sequence identical to the ready=1 case, with no dropped or duplicated items.
- Overrun: second i_digest_valid with a different value mid-stream -> one o_overrun pulse; the stream completes with the first digest. A third digest issued two cycles after o_done is accepted normally.
- Reset mid-stream after 10 transfers -> o_byte_valid=0 and o_busy=0 immediately, no o_done. A fresh digest afterwards streams from item 0.
